// File: rtl/decode_if.sv
// decode_if: fetch->decode and decode->execute channels for decode_stage.
//   slave  : the decode stage (consumes fetch side, drives execute side)
//   master : the surrounding pipeline / testbench
// Signals:
//   flush                         synchronous pipeline flush
//   in_valid/in_ready/in_instr/in_pc   fetch handshake + payload
//   out_valid/out_ready/out_pc         execute handshake + registered PC
//   opcode..rd, imm                    decoded fields, sign-extended immediate
//   alu_src, reg_write, is_*, illegal  control flags
//   decode_count                       accepted-instruction counter
interface decode_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       rd;
  logic [XLEN-1:0]  imm;
  logic             alu_src;
  logic             reg_write;
  logic             is_load;
  logic             is_store;
  logic             is_branch;
  logic             is_jump;
  logic             illegal;
  logic [CNT_W-1:0] decode_count;

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, opcode, funct3, funct7, rs1, rs2, rd,
           imm, alu_src, reg_write, is_load, is_store, is_branch, is_jump,
           illegal, decode_count
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, opcode, funct3, funct7, rs1, rs2, rd,
           imm, alu_src, reg_write, is_load, is_store, is_branch, is_jump,
           illegal, decode_count
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode between fetch and execute.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset, clears every output register
//   bus  decode_if.slave: fetch handshake in, decoded bundle + flags out
// One instruction per in_valid/in_ready handshake; bundle appears one cycle
// later and holds while execute stalls. flush drops the held bundle and
// blocks acceptance on that edge.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic     clk,
  input  logic     rst,
  decode_if.slave  bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            alu_src;
    logic            reg_write;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jump;
    logic            illegal;
  } dec_t;

  dec_t             dec_d, dec_q;
  logic             valid_q;
  logic [CNT_W-1:0] count_q;
  logic             accept;

  logic [31:0]      ins;
  logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign ins = bus.in_instr;

  // Signed casts sign-extend each format from instr[31] to XLEN.
  assign imm_i  = XLEN'($signed(ins[31:20]));
  assign imm_s  = XLEN'($signed({ins[31:25], ins[11:7]}));
  assign imm_b  = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({ins[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
  assign imm_sh = XLEN'(ins[24:20]);   // shamt is unsigned

  always_comb begin
    dec_d        = '0;
    dec_d.pc     = bus.in_pc;
    dec_d.opcode = ins[6:0];
    unique case (ins[6:0])
      OP_R: begin
        dec_d.funct3    = ins[14:12];
        dec_d.funct7    = ins[31:25];
        dec_d.rs1       = ins[19:15];
        dec_d.rs2       = ins[24:20];
        dec_d.rd        = ins[11:7];
        dec_d.reg_write = 1'b1;
      end
      OP_IMM: begin
        dec_d.funct3    = ins[14:12];
        dec_d.rs1       = ins[19:15];
        dec_d.rd        = ins[11:7];
        dec_d.reg_write = 1'b1;
        dec_d.alu_src   = 1'b1;
        // slli/srli/srai carry funct7 and a 5-bit shamt instead of imm12
        if (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) begin
          dec_d.funct7 = ins[31:25];
          dec_d.imm    = imm_sh;
        end else begin
          dec_d.imm    = imm_i;
        end
      end
      OP_LOAD, OP_JALR: begin
        dec_d.funct3    = ins[14:12];
        dec_d.rs1       = ins[19:15];
        dec_d.rd        = ins[11:7];
        dec_d.imm       = imm_i;
        dec_d.reg_write = 1'b1;
        dec_d.alu_src   = 1'b1;
        dec_d.is_load   = (ins[6:0] == OP_LOAD);
        dec_d.is_jump   = (ins[6:0] == OP_JALR);
      end
      OP_STORE: begin
        dec_d.funct3   = ins[14:12];
        dec_d.rs1      = ins[19:15];
        dec_d.rs2      = ins[24:20];
        dec_d.imm      = imm_s;
        dec_d.alu_src  = 1'b1;
        dec_d.is_store = 1'b1;
      end
      OP_BRANCH: begin
        dec_d.funct3    = ins[14:12];
        dec_d.rs1       = ins[19:15];
        dec_d.rs2       = ins[24:20];
        dec_d.imm       = imm_b;
        dec_d.alu_src   = 1'b1;
        dec_d.is_branch = 1'b1;
        // funct3 010/011 are unassigned branch encodings
        dec_d.illegal   = (ins[14:13] == 2'b01);
      end
      OP_JAL: begin
        dec_d.rd        = ins[11:7];
        dec_d.imm       = imm_j;
        dec_d.reg_write = 1'b1;
        dec_d.alu_src   = 1'b1;
        dec_d.is_jump   = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        dec_d.rd        = ins[11:7];
        dec_d.imm       = imm_u;
        dec_d.reg_write = 1'b1;
        dec_d.alu_src   = 1'b1;
      end
      default: begin
        // Unknown opcode: report raw fields, no class flags, imm = 0.
        dec_d.funct3  = ins[14:12];
        dec_d.funct7  = ins[31:25];
        dec_d.rs1     = ins[19:15];
        dec_d.rs2     = ins[24:20];
        dec_d.rd      = ins[11:7];
        dec_d.illegal = 1'b1;
      end
    endcase
  end

  assign bus.in_ready = !bus.flush && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      dec_q   <= dec_d;
      valid_q <= 1'b1;
      count_q <= count_q + CNT_W'(1);
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.out_pc       = dec_q.pc;
  assign bus.opcode       = dec_q.opcode;
  assign bus.funct3       = dec_q.funct3;
  assign bus.funct7       = dec_q.funct7;
  assign bus.rs1          = dec_q.rs1;
  assign bus.rs2          = dec_q.rs2;
  assign bus.rd           = dec_q.rd;
  assign bus.imm          = dec_q.imm;
  assign bus.alu_src      = dec_q.alu_src;
  assign bus.reg_write    = dec_q.reg_write;
  assign bus.is_load      = dec_q.is_load;
  assign bus.is_store     = dec_q.is_store;
  assign bus.is_branch    = dec_q.is_branch;
  assign bus.is_jump      = dec_q.is_jump;
  assign bus.illegal      = dec_q.illegal;
  assign bus.decode_count = count_q;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered RV32I instruction decode stage that sits between fetch and execute.
- Accepts one 32-bit instruction plus PC per valid/ready handshake.
- Produces the decoded fields, a sign-extended immediate of width XLEN, and control flags one cycle later.
- Output holds under backpressure; supports pipeline flush and counts decoded instructions.

Parameters:
XLEN, 32, width of the PC and immediate datapath; must be ≥ 32.
CNT_W, 16, width of the decoded-instruction counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
flush  in  1  synchronous pipeline flush
in_valid  in  1  fetch has an instruction
in_ready  out  1  stage can accept this cycle
in_instr  in  32  raw instruction
in_pc  in  XLEN  PC of in_instr
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
out_pc  out  XLEN  registered PC
opcode  out  7  instr[6:0]
funct3  out  3  instr[14:12], or 0 for U/J formats
funct7  out  7  instr[31:25] for R-type and OP-IMM shifts, else 0
rs1  out  5  instr[19:15], or 0 for U/J formats
rs2  out  5  instr[24:20] for R/S/B formats, else 0
rd  out  5  instr[11:7] for R/I/U/J formats, else 0
imm  out  XLEN  sign-extended immediate
alu_src  out  1  0 = register operand, 1 = immediate
reg_write, is_load, is_store, is_branch, is_jump  out  1 each  class flags
illegal  out  1  unsupported encoding
decode_count  out  CNT_W  accepted-instruction counter

Behaviour:
- Reset (async, rst=1): every output register is cleared to 0, including out_valid and decode_count. in_ready is 1 whenever rst=0 and the ready equation allows it.
- Ready equation: in_ready = !flush && (!out_valid || out_ready). This is combinational, so the stage sustains full throughput.
- Accept: on in_valid && in_ready at a rising edge, all output fields load the decode of in_instr/in_pc. out_valid=1 from the next cycle. Latency is 1 cycle.
- Drain: if out_valid && out_ready and no accept that edge, out_valid → 0. Fields hold their last values.
- Hold: if out_valid && !out_ready, every output is stable until the edge where out_ready=1.
- Flush: when flush=1 at an edge, out_valid → 0 and nothing is accepted. Flush wins over a simultaneous accept or handshake, and decode_count does not increment.
- decode_count: +1 on each accept. Wraps from 2^CNT_W−1 to 0.
- Immediate formats (all sign-extended from instr[31] to XLEN):
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R: imm = 0
- OP-IMM shifts (funct3 001/101): imm = zero-extended instr[24:20]; funct7 = instr[31:25].
- Opcode decode:
  - 0110011 R: reg_write=1, alu_src=0.
  - 0010011 I: reg_write=1, alu_src=1.
  - 0000011 load: I format, is_load=1, reg_write=1, alu_src=1.
  - 0100011 store: S format, is_store=1, alu_src=1.
  - 1100011 branch: B format, is_branch=1, alu_src=1. funct3 010 or 011 → illegal.
  - 1101111 jal: J format. 1100111 jalr: I format. Both set is_jump=1, reg_write=1, alu_src=1.
  - 0110111 lui, 0010111 auipc: U format, reg_write=1, alu_src=1.
- Any other opcode: illegal=1; all class flags and reg_write = 0; imm = 0; raw fields still reported. Illegal bundles still handshake normally.
- rst asserted mid-transfer: the bundle is discarded and no partial state survives.

Test Plan:
1. addi x5,x4,-1 (0xFFF20293, out_ready=1) → next cycle out_valid=1, rs1=4, rd=5, rs2=0, funct7=0, imm=0xFFFFFFFF, alu_src=1, reg_write=1, decode_count=1.
2. beq x1,x2,+48 (0000001_00010_00001_000_10000_1100011) → imm=0x30, rd=0, rs2=2, is_branch=1, reg_write=0. Repeat with funct3=010 → illegal=1.
3. srai x5,x4,3 (0100000_00011_00100_101_00101_0010011) → funct7=0100000, imm=3. Then add x3,x2,x1 → alu_src=0, imm=0.
4. Back-to-back valids with out_ready low for 3 cycles → in_ready=0, outputs frozen for 3 cycles; after release, one bundle per cycle with no loss or duplication (counter matches).
5. flush asserted together with in_valid while out_valid=1 → next cycle out_valid=0, decode_count unchanged. Opcode 0000000 → illegal=1, all flags 0. With CNT_W=2, 5 accepts → decode_count=1.
6. rst pulsed between clock edges while out_valid=1 → immediately out_valid=0, decode_count=0. First accept after release decodes correctly.
